antisat_key_loader: RTL and testbench

ANTISAT_KEY_LOADER -- requirements
Module: antisat_key_loader

---
 rtl/antisat_pkg.sv | 20 ++
 rtl/antisat_key_chk.sv | 26 ++
 rtl/antisat_key_loader.sv | 132 +++++++++++++
 tb/tb_antisat_key_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/antisat_pkg.sv
// -----------------------------------------------------------------------------
// antisat_pkg
// Shared definitions for the Anti-SAT key loader: default widths, the retry
// budget and the loader FSM state type.
// -----------------------------------------------------------------------------
package antisat_pkg;

    localparam int KEY_W_DEF     = 24;
    localparam int CHK_W_DEF     = 8;
    localparam int MAX_TRIES_DEF = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CHECK   = 3'd2,
        DONE    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

endpackage

// File: rtl/antisat_key_chk.sv
// -----------------------------------------------------------------------------
// antisat_key_chk
// Combinational checksum: XOR of all whole bytes of the key.
//   key_i  [KEY_W-1:0]  candidate key from the shadow register
//   chk_o  [CHK_W-1:0]  byte-XOR checksum
// -----------------------------------------------------------------------------
module antisat_key_chk
    import antisat_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic [KEY_W-1:0] key_i,
    output logic [CHK_W-1:0] chk_o
);

    localparam int N_BYTES = KEY_W / 8;

    always_comb begin
        chk_o = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            chk_o = chk_o ^ CHK_W'(key_i[b*8 +: 8]);
        end
    end

endmodule

// File: rtl/antisat_key_loader.sv
// -----------------------------------------------------------------------------
// antisat_key_loader
// Serially loads an Anti-SAT key plus checksum (MSB first), verifies it and
// exposes it once, write-once, to the locked netlist. Repeated bad loads
// exhaust a retry budget and lock the loader until reset.
//   clk, rst_n        clock, async active-low reset
//   start             one-cycle load request (honoured only in IDLE)
//   ser_data/valid    serial bit stream in
//   ser_ready         loader accepts a bit this cycle (SHIFT only)
//   key_out           verified key, zero unless key_valid
//   key_valid         key_out holds a verified key
//   load_err          one-cycle pulse on checksum mismatch
//   locked_out        retry budget exhausted
//   busy              load in progress (SHIFT or CHECK)
//
// state   | meaning
// IDLE    | waiting for start
// SHIFT   | accepting KEY_W+CHK_W serial bits
// CHECK   | one-cycle checksum compare
// DONE    | key verified and exposed; terminal until reset
// LOCKOUT | retry budget spent; terminal until reset
// -----------------------------------------------------------------------------
module antisat_key_loader
    import antisat_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int CHK_W     = CHK_W_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_data,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             locked_out,
    output logic             busy
);

    localparam int TOTAL = KEY_W + CHK_W;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    state_e             state_q, state_d;
    logic [TOTAL-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TRY_W-1:0]   tries_inc;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CHK_W-1:0]   chk_calc;
    logic               chk_match;

    antisat_key_chk #(
        .KEY_W (KEY_W),
        .CHK_W (CHK_W)
    ) u_chk (
        .key_i (shadow_q[TOTAL-1 -: KEY_W]),
        .chk_o (chk_calc)
    );

    assign chk_match = (chk_calc == shadow_q[CHK_W-1:0]);
    assign tries_inc = tries_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            tries_q  <= '0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            tries_q  <= tries_d;
            key_q    <= key_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        key_d    = key_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    shadow_d = {shadow_q[TOTAL-2:0], ser_data};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (chk_match) begin
                    state_d = DONE;
                    key_d   = shadow_q[TOTAL-1 -: KEY_W];
                end else begin
                    tries_d = tries_inc;
                    state_d = (tries_inc == TRY_LIMIT) ? LOCKOUT : IDLE;
                end
            end
            DONE:    state_d = DONE;
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    assign ser_ready  = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT) || (state_q == CHECK);
    assign key_valid  = (state_q == DONE);
    assign load_err   = (state_q == CHECK) && !chk_match;
    assign locked_out = (state_q == LOCKOUT);
    // key_q is only ever written on the way into DONE; the gate keeps the
    // netlist key inputs at zero in every other state regardless.
    assign key_out    = key_valid ? key_q : '0;

endmodule

// File: tb/tb_antisat_key_loader.sv
// -----------------------------------------------------------------------------
// tb_antisat_key_loader
// Directed bench for antisat_key_loader with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_antisat_key_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic [23:0] key_out;
    logic        key_valid;
    logic        load_err;
    logic        locked_out;
    logic        busy;

    int vectors;
    int miscompares;
    int xfer_cnt;

    antisat_key_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .load_err   (load_err),
        .locked_out (locked_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ser_valid && ser_ready) xfer_cnt++;
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives nbits of w, MSB first, one per cycle; gap inserts an idle
    // (ser_valid=0) cycle after every bit.
    task automatic send_bits(input logic [31:0] w, input int nbits, input bit gap);
        for (int i = 31; i > 31 - nbits; i--) begin
            ser_data  = w[i];
            ser_valid = 1'b1;
            @(negedge clk);
            if (gap) begin
                ser_valid = 1'b0;
                ser_data  = 1'b0;
                @(negedge clk);
            end
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    // Full load ending in a checksum mismatch; checks the one-cycle pulse.
    task automatic bad_load(input string tag);
        pulse_start();
        send_bits(32'hA5C33C5B, 32, 1'b0);
        vectors++;
        if (load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL %s load_err_pulse: got %b expected 1", tag, load_err);
        end
        @(negedge clk);
        vectors++;
        if (load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s load_err_one_cycle: got %b expected 0", tag, load_err);
        end
        vectors++;
        if (key_out !== 24'h0 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s bad_key_hidden: got key_out=%h key_valid=%b expected 000000/0", tag, key_out, key_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({ser_ready, key_valid, load_err, locked_out, busy} !== 5'b0 || key_out !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b kv=%b err=%b lock=%b busy=%b key=%h expected all 0",
                     ser_ready, key_valid, load_err, locked_out, busy, key_out);
        end
        // ser_valid without start must not advance anything
        send_bits(32'hFFFF_FFFF, 4, 1'b0);
        vectors++;
        if (ser_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_valid: got rdy=%b busy=%b expected 0/0", ser_ready, busy);
        end
    endtask

    task automatic test_good_load();
        pulse_start();
        vectors++;
        if (ser_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_entry: got rdy=%b busy=%b expected 1/1", ser_ready, busy);
        end
        send_bits(32'hA5C33C5A, 32, 1'b0);
        vectors++;
        if (load_err !== 1'b0 || key_valid !== 1'b0 || busy !== 1'b1 || ser_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL good_check_cycle: got err=%b kv=%b busy=%b rdy=%b expected 0/0/1/0",
                     load_err, key_valid, busy, ser_ready);
        end
        vectors++;
        if (key_out !== 24'h0) begin
            miscompares++;
            $display("FAIL good_check_key_hidden: got %h expected 000000", key_out);
        end
        @(negedge clk);
        vectors++;
        if (key_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL good_done: got kv=%b busy=%b expected 1/0", key_valid, busy);
        end
        vectors++;
        if (key_out !== 24'hA5C33C) begin
            miscompares++;
            $display("FAIL good_key_out: got %h expected a5c33c", key_out);
        end
    endtask

    task automatic test_write_once();
        pulse_start();
        vectors++;
        if (ser_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ignores_start: got rdy=%b busy=%b expected 0/0", ser_ready, busy);
        end
        send_bits(32'h12345644, 32, 1'b0);
        repeat (2) @(negedge clk);
        vectors++;
        if (key_out !== 24'hA5C33C || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL write_once_key: got key=%h kv=%b expected a5c33c/1", key_out, key_valid);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        bad_load("bad1");
        vectors++;
        if (busy !== 1'b0 || locked_out !== 1'b0 || ser_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bad1_back_idle: got busy=%b lock=%b rdy=%b expected 0/0/0", busy, locked_out, ser_ready);
        end
    endtask

    task automatic test_lockout();
        bad_load("bad2");
        vectors++;
        if (locked_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bad2_not_locked: got %b expected 0", locked_out);
        end
        bad_load("bad3");
        vectors++;
        if (locked_out !== 1'b1) begin
            miscompares++;
            $display("FAIL bad3_locked: got %b expected 1", locked_out);
        end
        pulse_start();
        send_bits(32'hA5C33C5A, 8, 1'b0);
        vectors++;
        if (ser_ready !== 1'b0 || busy !== 1'b0 || locked_out !== 1'b1 || key_out !== 24'h0) begin
            miscompares++;
            $display("FAIL lockout_terminal: got rdy=%b busy=%b lock=%b key=%h expected 0/0/1/000000",
                     ser_ready, busy, locked_out, key_out);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        pulse_start();
        xfer_cnt = 0;
        send_bits(32'hA5C33C5A, 32, 1'b1);
        // gap cycle after the last bit already consumed the CHECK cycle
        vectors++;
        if (xfer_cnt !== 32) begin
            miscompares++;
            $display("FAIL bp_transfers: got %0d expected 32", xfer_cnt);
        end
        vectors++;
        if (key_valid !== 1'b1 || key_out !== 24'hA5C33C) begin
            miscompares++;
            $display("FAIL bp_key: got kv=%b key=%h expected 1/a5c33c", key_valid, key_out);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        pulse_start();
        send_bits(32'hA5C33C5A, 10, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ser_ready, key_valid, load_err, locked_out, busy} !== 5'b0 || key_out !== 24'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got rdy=%b kv=%b err=%b lock=%b busy=%b key=%h expected all 0",
                     ser_ready, key_valid, load_err, locked_out, busy, key_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_bits(32'hFFFF_FFFF, 3, 1'b0);
        vectors++;
        if (ser_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_needs_start: got rdy=%b busy=%b expected 0/0", ser_ready, busy);
        end
        pulse_start();
        send_bits(32'hA5C33C5A, 32, 1'b0);
        @(negedge clk);
        vectors++;
        if (key_valid !== 1'b1 || key_out !== 24'hA5C33C) begin
            miscompares++;
            $display("FAIL mid_reset_reload: got kv=%b key=%h expected 1/a5c33c", key_valid, key_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        xfer_cnt    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        ser_valid   = 1'b0;
        ser_data    = 1'b0;
        test_reset();
        test_good_load();
        test_write_once();
        test_bad_checksum();
        test_lockout();
        test_backpressure();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
